uart_tx_queue: RTL and testbench
================================

UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16: byte queue depth, power of two, at least 2.
REQ-002 SHALL have parameter PULSE_CYCLES, default 4: cycles sendOnLow is held low per byte.
REQ-003 SHALL have parameter HOLD_CYCLES, default 264488: cycles dataOut is held after the pulse (10 x 234 bit frames + 262143 debounce + margin).
REQ-004 SHALL have port clk, input, 1: sole clock, all logic on posedge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port wr_data, input, 8: byte to enqueue.
REQ-007 SHALL have port wr_valid, input, 1: enqueue request.
REQ-008 SHALL have port wr_ready, output, 1: high when the queue is not full.
REQ-009 SHALL have port dataOut, output, 8: byte presented to the UART transmitter.
REQ-010 SHALL have port sendOnLow, output, 1: active-low send strobe to the UART transmitter.
REQ-011 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-012 SHALL have port level, output, $clog2(DEPTH)+1: current queue occupancy.
REQ-013 SHALL have port ovf, output, 1: sticky overflow flag (see Configuration).

Function
REQ-014 SHALL accept a byte on a clk edge where wr_valid=1 and wr_ready=1; level increments at that edge.
REQ-015 SHALL drive wr_ready combinationally as level != DEPTH; a write while full is dropped even if a pop occurs in the same cycle.
REQ-016 SHALL have FSM states IDLE, SEND and HOLD.
REQ-017 IDLE with level > 0 SHALL, on the next edge: pop the head, register it to dataOut, drive sendOnLow=0 and enter SEND.
REQ-018 SEND SHALL keep sendOnLow=0 for exactly PULSE_CYCLES cycles, then drive sendOnLow=1 and enter HOLD.
REQ-019 HOLD SHALL keep dataOut stable for exactly HOLD_CYCLES cycles, then enter IDLE.
REQ-020 A write to an empty, idle queue SHALL see dataOut valid and sendOnLow low 2 edges after acceptance.
REQ-021 A simultaneous write and pop when not full SHALL leave level unchanged and preserve FIFO order.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH.
REQ-023 dataOut SHALL retain the last sent byte in IDLE.
REQ-024 With the queue non-empty, back-to-back bytes SHALL be spaced exactly 1+PULSE_CYCLES+HOLD_CYCLES cycles apart on sendOnLow falling edges.
REQ-025 The cycle counter SHALL be sized for max(PULSE_CYCLES, HOLD_CYCLES) and SHALL NOT wrap.

Reset
REQ-026 rst=1 SHALL immediately set: dataOut=0, sendOnLow=1, state IDLE, level 0, pointers 0, counter 0, ovf 0.
REQ-027 Reset mid-SEND or mid-HOLD SHALL abort the byte and flush the queue; no byte is sent after release until a new write.
REQ-028 Queue storage SHALL need no reset.

Configuration
REQ-029 Macro UART_TX_QUEUE_OVF_EN defined: ovf SHALL set on any cycle with wr_valid=1 and wr_ready=0, and clear only on rst.
REQ-030 Macro UART_TX_QUEUE_OVF_EN undefined: ovf SHALL be tied to 0 and no overflow logic SHALL be synthesized.

Structure
REQ-031 Package uart_pkg SHALL hold the FSM state typedef and the default DELAY_FRAMES (234), PULSE_CYCLES and HOLD_CYCLES constants.
REQ-032 Storage and pointers SHALL live in sub-module uart_byte_fifo; the FSM and counter SHALL live in uart_tx_queue.

Verification (DEPTH=4, PULSE_CYCLES=2, HOLD_CYCLES=40)
REQ-033 Write 0xA5 when idle -> dataOut=0xA5 and sendOnLow low 2 edges later, low for 2 cycles, then busy for 40 more.
REQ-034 Write 0x01,0x02,0x03 back-to-back -> sendOnLow falls 3 times, 43 cycles apart, with dataOut 0x01, 0x02, 0x03 in order.
REQ-035 Write 5 bytes with transmitter stalled in HOLD -> wr_ready=0 at level 4, 5th byte dropped; ovf=1 with macro, 0 without.
REQ-036 Assert rst during HOLD with level=2 -> sendOnLow=1, level=0, busy=0 immediately; no further strobes after release.
REQ-037 Write in the same cycle as a pop with level=2 -> level stays 2; output order matches write order across pointer wrap.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and default timing for the UART transmit queue.
// Default HOLD_CYCLES covers 10 bit frames of DELAY_FRAMES cycles, the receiver debounce window and a small margin.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      HOLD = 2'd2
   } txState_t;

   localparam int DELAY_FRAMES = 234;
   localparam int PULSE_CYCLES = 4;
   localparam int HOLD_CYCLES  = 10 * DELAY_FRAMES + 262143 + 5;

   function automatic int maxOf(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with power-of-two depth; pointers wrap naturally, storage is not reset.
module uart_byte_fifo #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DATA_W-1:0]        wrData,
   input  logic                     push,
   input  logic                     pop,
   output logic [DATA_W-1:0]        head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wrPtr;
   logic [AW-1:0]     rdPtr;
   logic              doPush;
   logic              doPop;

   // A full queue refuses writes even when a pop frees a slot in the same cycle.
   assign full   = (count == CW'(DEPTH));
   assign doPush = push && !full;
   assign doPop  = pop && (count != '0);
   assign head   = mem[rdPtr];

   always_ff @(posedge clk) begin
      if (doPush) begin
         mem[wrPtr] <= wrData;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) begin
            wrPtr <= wrPtr + AW'(1);
         end
         if (doPop) begin
            rdPtr <= rdPtr + AW'(1);
         end
         case ({doPush, doPop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_queue.sv
// Queues bytes and hands them one at a time to a UART transmitter using an active-low send strobe.
// Define UART_TX_QUEUE_OVF_EN to build the sticky overflow flag; otherwise ovf is tied low.
module uart_tx_queue #(
   parameter int DEPTH        = 16,
   parameter int PULSE_CYCLES = uart_pkg::PULSE_CYCLES,
   parameter int HOLD_CYCLES  = uart_pkg::HOLD_CYCLES
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               wr_data,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   output logic [7:0]               dataOut,
   output logic                     sendOnLow,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     ovf
);

   import uart_pkg::*;

   localparam int CNT_MAX = maxOf(PULSE_CYCLES, HOLD_CYCLES);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);

   txState_t         state;
   txState_t         nextState;
   logic [CNT_W-1:0] cnt;
   logic             pop;
   logic             full;
   logic [7:0]       head;

   uart_byte_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (8)
   ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .wrData (wr_data),
      .push   (wr_valid),
      .pop    (pop),
      .head   (head),
      .count  (level),
      .full   (full)
   );

   assign wr_ready = !full;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (level != '0)       nextState = SEND;
         SEND:    if (cnt == PULSE_LAST) nextState = HOLD;
         HOLD:    if (cnt == HOLD_LAST)  nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      pop       = (state == IDLE) && (level != '0);
      sendOnLow = (state != SEND);
      busy      = (state != IDLE);
   end

   // The counter restarts on every state change, so it never runs past the longer phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (nextState != state) begin
         cnt <= '0;
      end else if (state != IDLE) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dataOut <= '0;
      end else if (pop) begin
         dataOut <= head;
      end
   end

`ifdef UART_TX_QUEUE_OVF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf <= 1'b0;
      end else if (wr_valid && !wr_ready) begin
         ovf <= 1'b1;
      end
   end
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with DEPTH=4, PULSE_CYCLES=2, HOLD_CYCLES=40.
module tb_uart_tx_queue;

   localparam int DEPTH   = 4;
   localparam int PULSE   = 2;
   localparam int HOLD    = 40;
   localparam int SPACING = 1 + PULSE + HOLD;
`ifdef UART_TX_QUEUE_OVF_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] wr_data;
   logic       wr_valid;
   logic       wr_ready;
   logic [7:0] dataOut;
   logic       sendOnLow;
   logic       busy;
   logic [2:0] level;
   logic       ovf;

   uart_tx_queue #(
      .DEPTH        (DEPTH),
      .PULSE_CYCLES (PULSE),
      .HOLD_CYCLES  (HOLD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_data   (wr_data),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .dataOut   (dataOut),
      .sendOnLow (sendOnLow),
      .busy      (busy),
      .level     (level),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit         rstBefore;
      bit         wv;
      logic [7:0] wd;
      logic [2:0] lvl;
      bit         rdy;
      bit         sol;
      bit         bsy;
      logic [7:0] dout;
      bit         ovfIfEn;
   } vec_t;

   vec_t       tbl [11];
   int         nChecks = 0;
   int         nFails  = 0;
   bit         prevSol = 1'b1;
   logic [7:0] gotData [$];
   int         gotCyc  [$];
   logic [7:0] expData [$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic stepMon();
      step();
      if (prevSol && !sendOnLow) begin
         gotData.push_back(dataOut);
         gotCyc.push_back(cyc);
      end
      prevSol = sendOnLow;
   endtask

   task automatic drive(input bit v, input logic [7:0] d);
      wr_valid = v;
      wr_data  = d;
   endtask

   task automatic doReset(input string tag);
      rst = 1'b1;
      drive(1'b0, 8'h00);
      step();
      step();
      rst = 1'b0;
      check({tag, ".rstLevel"}, 32'(level),     32'd0);
      check({tag, ".rstReady"}, 32'(wr_ready),  32'd1);
      check({tag, ".rstSol"},   32'(sendOnLow), 32'd1);
      check({tag, ".rstBusy"},  32'(busy),      32'd0);
      check({tag, ".rstData"},  32'(dataOut),   32'd0);
      check({tag, ".rstOvf"},   32'(ovf),       32'd0);
      prevSol = 1'b1;
      gotData.delete();
      gotCyc.delete();
   endtask

   task automatic applyVec(input int i);
      if (tbl[i].rstBefore) doReset($sformatf("vec%0d", i));
      drive(tbl[i].wv, tbl[i].wd);
      step();
      check($sformatf("vec%0d.level", i), 32'(level),     32'(tbl[i].lvl));
      check($sformatf("vec%0d.ready", i), 32'(wr_ready),  32'(tbl[i].rdy));
      check($sformatf("vec%0d.sol", i),   32'(sendOnLow), 32'(tbl[i].sol));
      check($sformatf("vec%0d.busy", i),  32'(busy),      32'(tbl[i].bsy));
      check($sformatf("vec%0d.data", i),  32'(dataOut),   32'(tbl[i].dout));
      check($sformatf("vec%0d.ovf", i),   32'(ovf),       32'(tbl[i].ovfIfEn & OVF_ON));
   endtask

   task automatic collect(input int n);
      for (int k = 0; k < n; k++) stepMon();
   endtask

   task automatic checkStrobes(input string tag);
      check({tag, ".count"}, 32'(gotData.size()), 32'(expData.size()));
      for (int k = 0; k < expData.size(); k++) begin
         if (k < gotData.size()) check($sformatf("%s.data%0d", tag, k), 32'(gotData[k]), 32'(expData[k]));
         else check($sformatf("%s.data%0d", tag, k), 32'hFFFF_FFFF, 32'(expData[k]));
         if (k > 0 && k < gotCyc.size())
            check($sformatf("%s.gap%0d", tag, k), 32'(gotCyc[k] - gotCyc[k-1]), 32'(SPACING));
      end
   endtask

   task automatic waitIdle(input string tag);
      int n = 0;
      while (busy !== 1'b0 && n < 200) begin
         stepMon();
         n++;
      end
      check({tag, ".idleReached"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int holdBusy;
      rst = 1'b1;
      drive(1'b0, 8'h00);

      //            rst  wv  wd     lvl   rdy sol bsy dout   ovf
      tbl[0]  = '{1'b1, 1'b1, 8'hA5, 3'd1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
      tbl[1]  = '{1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0};
      tbl[4]  = '{1'b1, 1'b1, 8'h10, 3'd1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 8'h11, 3'd1, 1'b1, 1'b0, 1'b1, 8'h10, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, 8'h12, 3'd2, 1'b1, 1'b0, 1'b1, 8'h10, 1'b0};
      tbl[7]  = '{1'b0, 1'b1, 8'h13, 3'd3, 1'b1, 1'b1, 1'b1, 8'h10, 1'b0};
      tbl[8]  = '{1'b0, 1'b1, 8'h14, 3'd4, 1'b0, 1'b1, 1'b1, 8'h10, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 8'h15, 3'd4, 1'b0, 1'b1, 1'b1, 8'h10, 1'b1};
      tbl[10] = '{1'b0, 1'b0, 8'h00, 3'd4, 1'b0, 1'b1, 1'b1, 8'h10, 1'b1};

      // Single byte: strobe timing, then the hold window length.
      for (int i = 0; i <= 3; i++) applyVec(i);
      holdBusy = 0;
      for (int k = 0; k < HOLD - 1; k++) begin
         step();
         if (busy === 1'b1) holdBusy++;
      end
      check("a5.holdBusy", 32'(holdBusy), 32'(HOLD - 1));
      step();
      check("a5.idleBusy", 32'(busy),      32'd0);
      check("a5.idleSol",  32'(sendOnLow), 32'd1);
      check("a5.retained", 32'(dataOut),   32'hA5);

      // Fill while stalled in HOLD; the fifth byte must be dropped.
      for (int i = 4; i <= 10; i++) applyVec(i);
      prevSol = sendOnLow;
      gotData.delete();
      gotCyc.delete();
      collect(260);
      expData = '{8'h11, 8'h12, 8'h13, 8'h14};
      checkStrobes("full");
      check("full.drainLevel", 32'(level), 32'd0);
      check("full.ovfKept",    32'(ovf),   32'(OVF_ON));

      // Three back-to-back bytes.
      doReset("b2b");
      drive(1'b1, 8'h01); stepMon();
      drive(1'b1, 8'h02); stepMon();
      drive(1'b1, 8'h03); stepMon();
      drive(1'b0, 8'h00);
      collect(150);
      expData = '{8'h01, 8'h02, 8'h03};
      checkStrobes("b2b");

      // Reset in HOLD with two bytes queued.
      doReset("abort");
      drive(1'b1, 8'h30); step();
      drive(1'b1, 8'h31); step();
      drive(1'b1, 8'h32); step();
      drive(1'b0, 8'h00);
      step();
      step();
      check("abort.preLevel", 32'(level),     32'd2);
      check("abort.preSol",   32'(sendOnLow), 32'd1);
      check("abort.preBusy",  32'(busy),      32'd1);
      rst = 1'b1;
      #1;
      check("abort.sol",   32'(sendOnLow), 32'd1);
      check("abort.level", 32'(level),     32'd0);
      check("abort.busy",  32'(busy),      32'd0);
      check("abort.data",  32'(dataOut),   32'd0);
      step();
      rst = 1'b0;
      prevSol = 1'b1;
      gotData.delete();
      gotCyc.delete();
      collect(200);
      check("abort.noStrobe", 32'(gotData.size()), 32'd0);
      check("abort.idle",     32'(busy),           32'd0);

      // Write coinciding with a pop at level 2, across the pointer wrap.
      doReset("wrap");
      drive(1'b1, 8'h20); stepMon();
      drive(1'b1, 8'h21); stepMon();
      drive(1'b1, 8'h22); stepMon();
      drive(1'b0, 8'h00);
      check("wrap.level2", 32'(level), 32'd2);
      gotData.delete();
      gotCyc.delete();
      waitIdle("wrap.w1");
      drive(1'b1, 8'h23); stepMon();
      drive(1'b0, 8'h00);
      check("wrap.popWrite1.level", 32'(level),   32'd2);
      check("wrap.popWrite1.data",  32'(dataOut), 32'h21);
      waitIdle("wrap.w2");
      drive(1'b1, 8'h24); stepMon();
      drive(1'b0, 8'h00);
      check("wrap.popWrite2.level", 32'(level),   32'd2);
      check("wrap.popWrite2.data",  32'(dataOut), 32'h22);
      collect(150);
      expData = '{8'h21, 8'h22, 8'h23, 8'h24};
      checkStrobes("wrap");
      check("wrap.emptyLevel", 32'(level), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
